// File: rtl/line_refill_writer.sv
// Refill write stage: takes one line request, streams LINE_WORDS bus beats into the line RAM.
// Build option REFILL_CRITICAL_WORD_FIRST_EN starts the fill at the missed word and wraps.
module line_refill_writer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RAM_SIZE   = 1024,
    parameter int unsigned LINE_WORDS = 4,
    localparam int unsigned ADDR_W    = $clog2(RAM_SIZE),
    localparam int unsigned WORD_W    = $clog2(LINE_WORDS),
    localparam int unsigned LINE_W    = ADDR_W - WORD_W,
    localparam int unsigned BE_W      = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [LINE_W-1:0]     req_line,
    input  logic [WORD_W-1:0]     req_offset,
    input  logic                  beat_valid,
    output logic                  beat_ready,
    input  logic [DATA_WIDTH-1:0] beat_data,
    input  logic                  beat_last,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [BE_W-1:0]       ram_we,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  crit_valid,
    output logic [DATA_WIDTH-1:0] crit_data,
    output logic                  done_valid,
    output logic [LINE_W-1:0]     done_line,
    output logic                  done_err
);

    typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

    state_e                state_q, state_d;
    logic [LINE_W-1:0]     line_q, line_d;
    logic [WORD_W-1:0]     offset_q, offset_d;
    logic [WORD_W-1:0]     word_q, word_d;
    logic [WORD_W-1:0]     count_q, count_d;
    logic                  err_q, err_d;
    logic [ADDR_W-1:0]     ram_addr_q, ram_addr_d;
    logic [BE_W-1:0]       ram_we_q, ram_we_d;
    logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
    logic                  crit_valid_q, crit_valid_d;
    logic [DATA_WIDTH-1:0] crit_data_q, crit_data_d;
    logic                  done_valid_q, done_valid_d;
    logic                  done_err_q, done_err_d;
    logic [WORD_W-1:0]     start_word;
    logic                  handshake;
    logic                  last_beat;

`ifdef REFILL_CRITICAL_WORD_FIRST_EN
    assign start_word = req_offset;
`else
    assign start_word = '0;
`endif

    assign handshake = beat_valid && (state_q == StFill);
    assign last_beat = (count_q == WORD_W'(LINE_WORDS - 1));

    always_comb begin
        state_d      = state_q;
        line_d       = line_q;
        offset_d     = offset_q;
        word_d       = word_q;
        count_d      = count_q;
        err_d        = err_q;
        ram_addr_d   = ram_addr_q;
        ram_we_d     = '0;
        ram_wdata_d  = ram_wdata_q;
        crit_valid_d = 1'b0;
        crit_data_d  = crit_data_q;
        done_valid_d = 1'b0;
        done_err_d   = done_err_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    line_d   = req_line;
                    offset_d = req_offset;
                    word_d   = start_word;
                    count_d  = '0;
                    err_d    = 1'b0;
                    state_d  = StFill;
                end
            end
            StFill: begin
                if (handshake) begin
                    ram_addr_d  = {line_q, word_q};
                    ram_we_d    = '1;
                    ram_wdata_d = beat_data;
                    // The requested word is the one whose index matches the missed offset.
                    if (word_q == offset_q) begin
                        crit_valid_d = 1'b1;
                        crit_data_d  = beat_data;
                    end
                    word_d  = word_q + 1'b1;
                    count_d = count_q + 1'b1;
                    err_d   = err_q | (beat_last != last_beat);
                    // Beat count alone ends the line; beat_last only feeds the error flag.
                    if (last_beat) begin
                        state_d      = StDone;
                        done_valid_d = 1'b1;
                        done_err_d   = err_d;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            line_q       <= '0;
            offset_q     <= '0;
            word_q       <= '0;
            count_q      <= '0;
            err_q        <= 1'b0;
            ram_addr_q   <= '0;
            ram_we_q     <= '0;
            ram_wdata_q  <= '0;
            crit_valid_q <= 1'b0;
            crit_data_q  <= '0;
            done_valid_q <= 1'b0;
            done_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            line_q       <= line_d;
            offset_q     <= offset_d;
            word_q       <= word_d;
            count_q      <= count_d;
            err_q        <= err_d;
            ram_addr_q   <= ram_addr_d;
            ram_we_q     <= ram_we_d;
            ram_wdata_q  <= ram_wdata_d;
            crit_valid_q <= crit_valid_d;
            crit_data_q  <= crit_data_d;
            done_valid_q <= done_valid_d;
            done_err_q   <= done_err_d;
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign beat_ready = (state_q == StFill);
    assign ram_addr   = ram_addr_q;
    assign ram_we     = ram_we_q;
    assign ram_wdata  = ram_wdata_q;
    assign crit_valid = crit_valid_q;
    assign crit_data  = crit_data_q;
    assign done_valid = done_valid_q;
    assign done_line  = line_q;
    assign done_err   = done_err_q;

endmodule

// File: tb/tb_line_refill_writer.sv
// Bench for line_refill_writer: tasks drive refills and queue expected writes, crit and done
// events with their due cycle; a negedge monitor pops and compares them.
module tb_line_refill_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_line = '0;
    logic [1:0]  req_offset = '0;
    logic        beat_valid = 1'b0;
    logic        beat_ready;
    logic [31:0] beat_data = '0;
    logic        beat_last = 1'b0;
    logic [9:0]  ram_addr;
    logic [3:0]  ram_we;
    logic [31:0] ram_wdata;
    logic        crit_valid;
    logic [31:0] crit_data;
    logic        done_valid;
    logic [7:0]  done_line;
    logic        done_err;

    typedef struct {logic [9:0] addr; logic [31:0] data; int cyc;} wr_t;
    typedef struct {logic [31:0] data; int cyc;} crit_t;
    typedef struct {logic [7:0] line; logic err; int cyc;} done_t;

    wr_t         wq[$];
    crit_t       cq[$];
    done_t       dq[$];
    logic [31:0] last_crit = '0;
    int          compared = 0;
    int          mismatched = 0;
    int          cyc = 0;

    line_refill_writer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_line  (req_line),
        .req_offset(req_offset),
        .beat_valid(beat_valid),
        .beat_ready(beat_ready),
        .beat_data (beat_data),
        .beat_last (beat_last),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .crit_valid(crit_valid),
        .crit_data (crit_data),
        .done_valid(done_valid),
        .done_line (done_line),
        .done_err  (done_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin : monitor
        wr_t   e;
        crit_t c;
        done_t d;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (ram_we !== 4'h0 || (wq.size() > 0 && wq[0].cyc == cyc)) begin
                    compared++;
                    if (wq.size() == 0) begin
                        mismatched++;
                        $display("FAIL ram_write: unexpected we=%h addr=%0d data=%h cyc=%0d",
                                 ram_we, ram_addr, ram_wdata, cyc);
                    end else begin
                        e = wq.pop_front();
                        if (ram_we !== 4'hF || ram_addr !== e.addr || ram_wdata !== e.data ||
                            cyc != e.cyc) begin
                            mismatched++;
                            $display("FAIL ram_write: got we=%h addr=%0d data=%h cyc=%0d, want we=f addr=%0d data=%h cyc=%0d",
                                     ram_we, ram_addr, ram_wdata, cyc, e.addr, e.data, e.cyc);
                        end
                    end
                end
                if (crit_valid !== 1'b0 || (cq.size() > 0 && cq[0].cyc == cyc)) begin
                    compared++;
                    if (cq.size() == 0) begin
                        mismatched++;
                        $display("FAIL crit: unexpected crit_valid data=%h cyc=%0d", crit_data, cyc);
                    end else begin
                        c = cq.pop_front();
                        last_crit = c.data;
                        if (crit_valid !== 1'b1 || crit_data !== c.data || cyc != c.cyc) begin
                            mismatched++;
                            $display("FAIL crit: got valid=%b data=%h cyc=%0d, want valid=1 data=%h cyc=%0d",
                                     crit_valid, crit_data, cyc, c.data, c.cyc);
                        end
                    end
                end else begin
                    compared++;
                    if (crit_data !== last_crit) begin
                        mismatched++;
                        $display("FAIL crit_hold: got %h want %h cyc=%0d", crit_data, last_crit, cyc);
                    end
                end
                if (done_valid !== 1'b0 || (dq.size() > 0 && dq[0].cyc == cyc)) begin
                    compared++;
                    if (dq.size() == 0) begin
                        mismatched++;
                        $display("FAIL done: unexpected done_valid line=%0d err=%b cyc=%0d",
                                 done_line, done_err, cyc);
                    end else begin
                        d = dq.pop_front();
                        if (done_valid !== 1'b1 || done_line !== d.line || done_err !== d.err ||
                            cyc != d.cyc) begin
                            mismatched++;
                            $display("FAIL done: got valid=%b line=%0d err=%b cyc=%0d, want valid=1 line=%0d err=%b cyc=%0d",
                                     done_valid, done_line, done_err, cyc, d.line, d.err, d.cyc);
                        end
                    end
                end
            end
        end
    end

    // Asserts reset, checks every output immediately, holds it for hold cycles, then releases.
    task automatic test_reset(input int hold);
        req_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        compared++;
        if ({req_ready, beat_ready, ram_we, ram_addr, ram_wdata, crit_valid, crit_data,
             done_valid, done_line, done_err} !== {1'b1, 1'b0, 4'h0, 10'h0, 32'h0, 1'b0, 32'h0,
             1'b0, 8'h0, 1'b0}) begin
            mismatched++;
            $display("FAIL reset_values: rr=%b br=%b we=%h addr=%h wd=%h cv=%b cd=%h dv=%b dl=%h de=%b, want rr=1 and all else 0",
                     req_ready, beat_ready, ram_we, ram_addr, ram_wdata, crit_valid, crit_data,
                     done_valid, done_line, done_err);
        end
        wq.delete();
        cq.delete();
        dq.delete();
        last_crit = '0;
        repeat (hold) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_line(input int line, input int off, input logic [31:0] base,
                            input bit gaps, input logic [3:0] last_mask, input bit keep_req,
                            input int n_beats);
        int    start;
        int    crit_idx;
        int    guard;
        bit    err;
        wr_t   e;
        crit_t c;
        done_t d;
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
        start    = off;
        crit_idx = 0;
`else
        start    = 0;
        crit_idx = off;
`endif
        beat_valid = 1'b0;
        beat_last  = 1'b0;
        req_valid  = 1'b1;
        req_line   = line[7:0];
        req_offset = off[1:0];
        guard = 0;
        while (req_ready !== 1'b1 && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
        end
        compared++;
        if (req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL req_ready_timeout: got %b want 1", req_ready);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (!keep_req) req_valid = 1'b0;
        err = 1'b0;
        for (int i = 0; i < n_beats; i++) begin
            beat_valid = 1'b1;
            beat_data  = base + i;
            beat_last  = last_mask[i];
            compared++;
            if (beat_ready !== 1'b1 || req_ready !== 1'b0) begin
                mismatched++;
                $display("FAIL fill_ready: got beat_ready=%b req_ready=%b want 1/0",
                         beat_ready, req_ready);
            end
            e.addr = 10'(line * 4 + (start + i) % 4);
            e.data = base + i;
            e.cyc  = cyc + 1;
            wq.push_back(e);
            if (i == crit_idx) begin
                c.data = base + i;
                c.cyc  = cyc + 1;
                cq.push_back(c);
            end
            err = err | (last_mask[i] != (i == 3));
            if (i == 3) begin
                d.line = line[7:0];
                d.err  = err;
                d.cyc  = cyc + 1;
                dq.push_back(d);
            end
            @(posedge clk);
            #1;
            beat_valid = 1'b0;
            beat_last  = 1'b0;
            if (gaps && i < n_beats - 1) begin
                @(posedge clk);
                #1;
            end
        end
        if (n_beats != 4) return;
        compared++;
        if (req_ready !== 1'b0 || beat_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL done_ready: got req_ready=%b beat_ready=%b want 0/0",
                     req_ready, beat_ready);
        end
        if (keep_req) begin
            // Junk beat offered in DONE must not be taken.
            beat_valid = 1'b1;
            beat_data  = 32'hDEAD_BEEF;
            beat_last  = 1'b1;
            @(posedge clk);
            #1;
            compared++;
            if (req_ready !== 1'b1 || beat_ready !== 1'b0) begin
                mismatched++;
                $display("FAIL idle_after_done: got req_ready=%b beat_ready=%b want 1/0",
                         req_ready, beat_ready);
            end
            return;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        compared++;
        if (wq.size() + cq.size() + dq.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d/%0d/%0d pending write/crit/done want 0/0/0",
                     wq.size(), cq.size(), dq.size());
        end
    endtask

    task automatic test_basic();
        run_line(5, 0, 32'hA0, 1'b0, 4'b1000, 1'b0, 4);
    endtask

    task automatic test_critical_word();
        run_line(2, 2, 32'hD0, 1'b0, 4'b1000, 1'b0, 4);
    endtask

    task automatic test_gaps();
        run_line(9, 3, 32'h50, 1'b1, 4'b1000, 1'b0, 4);
    endtask

    task automatic test_early_last();
        run_line(12, 1, 32'h70, 1'b0, 4'b0010, 1'b0, 4);
    endtask

    task automatic test_reset_mid_fill();
        run_line(7, 1, 32'hC0, 1'b0, 4'b1000, 1'b0, 2);
        beat_valid = 1'b1;
        beat_data  = 32'hBAD0_0000;
        @(negedge clk);
        #2;
        test_reset(3);
        beat_valid = 1'b0;
        run_line(4, 0, 32'hE0, 1'b0, 4'b1000, 1'b0, 4);
    endtask

    task automatic test_back_to_back();
        run_line(3, 1, 32'h30, 1'b0, 4'b1000, 1'b1, 4);
        run_line(6, 2, 32'h60, 1'b0, 4'b1000, 1'b0, 4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset(2);
        test_basic();
        test_critical_word();
        test_gaps();
        test_early_last();
        test_reset_mid_fill();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/line_refill_writer.md
Name: line_refill_writer

Overview:
- Refill-side write stage of the cache data path.
- Accepts one line-refill request, consumes LINE_WORDS bus data beats through a valid/ready handshake, and drives the narrow byte-enabled write port of the simple dual-port line RAM downstream.
- Reports line completion and bus-protocol errors to the cache controller.

Parameters:
- DATA_WIDTH, 32, width of one bus beat and one RAM word; multiple of 8.
- RAM_SIZE, 1024, RAM depth in words; power of 2.
- LINE_WORDS, 4, words per cache line; power of 2, 2..16, divides RAM_SIZE.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active low.
- req_valid  in  1  refill request valid.
- req_ready  out  1  high only in IDLE.
- req_line  in  clog2(RAM_SIZE)-clog2(LINE_WORDS)  target line index.
- req_offset  in  clog2(LINE_WORDS)  missed word within the line.
- beat_valid  in  1  bus beat valid.
- beat_ready  out  1  high only in FILL.
- beat_data  in  DATA_WIDTH  beat payload.
- beat_last  in  1  bus marks this beat as final.
- ram_addr  out  clog2(RAM_SIZE)  RAM write word address = {line, word}.
- ram_we  out  DATA_WIDTH/8  byte write enables.
- ram_wdata  out  DATA_WIDTH  RAM write data.
- crit_valid  out  1  one-cycle pulse: requested word available.
- crit_data  out  DATA_WIDTH  requested word.
- done_valid  out  1  one-cycle pulse: line fully written.
- done_line  out  same as req_line  line just completed.
- done_err  out  1  qualifies done_valid: beat_last mismatch seen.

Behaviour:
- Reset (async, rst_n=0): state IDLE. req_ready=1, beat_ready=0, ram_we=0, ram_addr=0, ram_wdata=0, crit_valid=0, crit_data=0, done_valid=0, done_line=0, done_err=0. Reset mid-fill abandons the line; no further RAM writes.
- States: IDLE, FILL, DONE.
- IDLE:
  - On req_valid && req_ready: latch line into done_line.
  - Start word = req_offset when the optional feature is compiled in, otherwise 0.
  - Clear beat count and error flag; go to FILL.
- FILL:
  - Each cycle with beat_valid && beat_ready (a handshake) registers ram_addr={line, word}, ram_we=all ones, ram_wdata=beat_data.
  - These outputs are visible the cycle after the handshake: write latency 1 cycle. In cycles with no handshake, ram_we=0.
  - After each handshake, word increments modulo LINE_WORDS (wraps LINE_WORDS-1 -> 0) and count increments.
  - Error flag is set if beat_last != (count==LINE_WORDS-1) on any handshake.
  - The handshake with count==LINE_WORDS-1 moves to DONE, regardless of beat_last.
  - Early beat_last does not terminate the fill; the line always takes exactly LINE_WORDS beats.
- DONE (one cycle):
  - done_valid=1 and done_err=error flag.
  - ram_we carries the final word's write this same cycle.
  - Next state IDLE; req_ready returns high the cycle after done_valid.
- Handshake rules:
  - No request is accepted outside IDLE.
  - beat_data is sampled only on handshake.
  - beat_valid in IDLE/DONE is ignored, with beat_ready low.
- crit_valid:
  - Pulses together with the RAM write of the requested word, i.e. the cycle after the first handshake with the feature in.
  - crit_data holds that word until the next crit_valid.
- Throughput: a line of N beats arriving back-to-back occupies N+1 cycles from request accept to done_valid, plus 1 idle cycle before the next accept.
- All outputs are registered; no combinational path from beat inputs to RAM outputs.

Optional Feature:
- Macro REFILL_CRITICAL_WORD_FIRST_EN.
- Defined:
  - Fill starts at req_offset and wraps.
  - crit_valid pulses for the first beat.
- Undefined:
  - req_offset is ignored and the fill starts at word 0.
  - crit_valid pulses when the write of word req_offset is issued, i.e. the cycle after handshake number req_offset+1.
  - crit_data behaves identically in both builds.

Test Plan:
- Reset, then line 5, offset 0, beats 0xA0..0xA3 back-to-back with beat_last on the 4th -> RAM writes at addresses 20,21,22,23 with ram_we=4'hF; done_valid one cycle later with done_line=5, done_err=0.
- Feature in: line 2, offset 2, beats D0..D3 -> writes at addresses 10,11,8,9; crit_valid with crit_data=D0 the cycle after the first handshake.
- beat_valid toggled 1/0 every cycle -> ram_we low on gap cycles; 4 writes total; done after the 4th beat only.
- beat_last asserted on the 2nd beat and absent on the 4th -> still 4 writes; done_valid with done_err=1.
- rst_n pulsed low after 2 beats -> outputs immediately at reset values; no further writes; a fresh request is accepted cleanly with done_err=0.
- req_valid held high through FILL/DONE -> second request accepted only in IDLE after done_valid; no beat accepted outside FILL.
